// File: rtl/hazard_forward_ctrl_if.sv
// Decode-side instruction fields and execute-side control selects exchanged
// between the pipeline datapath and the hazard/forwarding controller.
interface hazard_forward_ctrl_if;
    logic       valid_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       regwrite_d;
    logic       load_d;
    logic       pcsrc_e;

    logic [1:0] forward_a_e;
    logic [1:0] forward_b_e;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;

    // Datapath side: presents decode fields and branch outcome, consumes selects.
    modport master (
        output valid_d, rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e,
        input  forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e
    );

    // Controller side.
    modport slave (
        input  valid_d, rs1_d, rs2_d, rd_d, regwrite_d, load_d, pcsrc_e,
        output forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard unit: shadows E/M/W register fields, drives operand-forwarding selects,
// load-use stalls of LOAD_LAT cycles (legal 1..3) and taken-branch flushes.
module hazard_forward_ctrl #(
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_forward_ctrl_if.slave  ctrl
);

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } ex_stage_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
    } wr_stage_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    // Cycles still owed after the hazard cycle itself.
    localparam logic [1:0] SCNT_LOAD = 2'(LOAD_LAT - 1);

    ex_stage_t ex_q;
    ex_stage_t ex_d;
    wr_stage_t mem_q;
    wr_stage_t mem_d;
    wr_stage_t wb_q;
    state_t    state_q;
    logic [1:0] scnt_q;

    logic branch;
    logic hz;
    logic stall;
    logic flush_e;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input wr_stage_t  mem,
        input wr_stage_t  wb
    );
        if (mem.regwrite && mem.rd != 5'd0 && mem.rd == src) return 2'b10;
        if (wb.regwrite && wb.rd != 5'd0 && wb.rd == src)     return 2'b01;
        return 2'b00;
    endfunction

    // Stall must act in the hazard cycle itself, so the controls are decoded
    // combinationally from the hazard term and the registered stall state.
    always_comb begin
        branch  = ctrl.pcsrc_e & ~rst;
        hz      = ctrl.valid_d && ex_q.load && (ex_q.rd != 5'd0) &&
                  ((ex_q.rd == ctrl.rs1_d) || (ex_q.rd == ctrl.rs2_d));
        stall   = (state_q == S_STALL) || hz;
        flush_e = stall || branch;
    end

    assign ctrl.forward_a_e = fwd_sel(ex_q.rs1, mem_q, wb_q);
    assign ctrl.forward_b_e = fwd_sel(ex_q.rs2, mem_q, wb_q);
    assign ctrl.stall_f     = stall & ~branch;
    assign ctrl.stall_d     = stall & ~branch;
    assign ctrl.flush_d     = branch;
    assign ctrl.flush_e     = flush_e;

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        ex_d  = '0;
        mem_d = '{rd: ex_q.rd, regwrite: ex_q.regwrite};
        if (!flush_e) begin
            ex_d = '{rs1:      ctrl.rs1_d,
                     rs2:      ctrl.rs2_d,
                     rd:       ctrl.rd_d,
                     regwrite: ctrl.regwrite_d & ctrl.valid_d,
                     load:     ctrl.load_d & ctrl.valid_d};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= S_IDLE;
            scnt_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking so every stage samples its pre-edge neighbour.
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= mem_q;
            case (state_q)
                S_IDLE: begin
                    if (hz && !branch && SCNT_LOAD != 2'd0) begin
                        state_q <= S_STALL;
                        scnt_q  <= SCNT_LOAD;
                    end
                end
                S_STALL: begin
                    // A taken branch abandons the remaining stall cycles.
                    if (branch || scnt_q == 2'd1) begin
                        state_q <= S_IDLE;
                        scnt_q  <= 2'd0;
                    end else begin
                        scnt_q <= scnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    scnt_q  <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Runs LOAD_LAT = 1, 2, 3 instances on one shared directed stimulus stream and
// checks each against an instruction-history model every cycle.
module tb_hazard_forward_ctrl;

    logic       clk;
    logic       rst;
    logic       valid_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       regwrite_d;
    logic       load_d;
    logic       pcsrc_e;

    logic [1:0] fa [3];
    logic [1:0] fb [3];
    logic       sf [3];
    logic       sd [3];
    logic       fd [3];
    logic       fe [3];

    int n_chk;
    int n_err;
    bit cmp_en;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_forward_ctrl_if bus ();
        assign bus.valid_d    = valid_d;
        assign bus.rs1_d      = rs1_d;
        assign bus.rs2_d      = rs2_d;
        assign bus.rd_d       = rd_d;
        assign bus.regwrite_d = regwrite_d;
        assign bus.load_d     = load_d;
        assign bus.pcsrc_e    = pcsrc_e;

        hazard_forward_ctrl #(.LOAD_LAT(g + 1)) dut (
            .clk  (clk),
            .rst  (rst),
            .ctrl (bus)
        );

        assign fa[g] = bus.forward_a_e;
        assign fb[g] = bus.forward_b_e;
        assign sf[g] = bus.stall_f;
        assign sd[g] = bus.stall_d;
        assign fd[g] = bus.flush_d;
        assign fe[g] = bus.flush_e;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } rec_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sf;
        logic       sd;
        logic       fd;
        logic       fe;
    } exp_t;

    // pipe[k][age]: instruction that entered execute 'age' edges ago
    // (0 = in E, 1 = in M, 2 = in W) for the LOAD_LAT = k+1 instance.
    rec_t pipe [3][3];
    int   left [3];   // stall cycles still owed after the current one

    function automatic logic [1:0] fwd_from(input int k, input logic [4:0] src);
        for (int age = 1; age <= 2; age++) begin
            if (pipe[k][age].wr && pipe[k][age].rd != 5'd0 && pipe[k][age].rd == src)
                return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic model_hz(input int k);
        return valid_d && pipe[k][0].ld && pipe[k][0].rd != 5'd0 &&
               (pipe[k][0].rd == rs1_d || pipe[k][0].rd == rs2_d);
    endfunction

    function automatic exp_t model_out(input int k);
        exp_t x;
        logic pc;
        logic want;
        pc   = pcsrc_e && !rst;
        want = (left[k] > 0) || model_hz(k);
        x.fa = fwd_from(k, pipe[k][0].rs1);
        x.fb = fwd_from(k, pipe[k][0].rs2);
        x.sf = want && !pc;
        x.sd = want && !pc;
        x.fd = pc;
        x.fe = want || pc;
        return x;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                left[k] = 0;
                for (int a = 0; a < 3; a++) pipe[k][a] = '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp_t x;
                rec_t ne;
                logic hz;
                x  = model_out(k);
                hz = model_hz(k);
                if (x.fe) ne = '0;
                else      ne = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                                 wr: regwrite_d && valid_d, ld: load_d && valid_d};
                if (pcsrc_e)      left[k] = 0;
                else if (left[k] > 0) left[k] = left[k] - 1;
                else if (hz)      left[k] = k;
                pipe[k][2] = pipe[k][1];
                pipe[k][1] = pipe[k][0];
                pipe[k][0] = ne;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                exp_t x;
                x = model_out(k);
                check($sformatf("model forward_a lat%0d", k + 1), fa[k], x.fa);
                check($sformatf("model forward_b lat%0d", k + 1), fb[k], x.fb);
                check($sformatf("model stall_f lat%0d", k + 1), 2'(sf[k]), 2'(x.sf));
                check($sformatf("model stall_d lat%0d", k + 1), 2'(sd[k]), 2'(x.sd));
                check($sformatf("model flush_d lat%0d", k + 1), 2'(fd[k]), 2'(x.fd));
                check($sformatf("model flush_e lat%0d", k + 1), 2'(fe[k]), 2'(x.fe));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic wr, input logic ld,
                        input logic pc);
        @(posedge clk);
        #1;
        valid_d    = v;
        rs1_d      = r1;
        rs2_d      = r2;
        rd_d       = rd;
        regwrite_d = wr;
        load_d     = ld;
        pcsrc_e    = pc;
        @(negedge clk);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        cmp_en     = 1'b0;
        rst        = 1'b1;
        valid_d    = 1'b0;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
        regwrite_d = 1'b0;
        load_d     = 1'b0;
        pcsrc_e    = 1'b0;

        // Reset state, with a branch request held to show reset masks it.
        pcsrc_e = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset forward_a", fa[k], 2'b00);
            check("reset flush_d", 2'(fd[k]), 2'b00);
            check("reset flush_e", 2'(fe[k]), 2'b00);
            check("reset stall_f", 2'(sf[k]), 2'b00);
        end
        pcsrc_e = 1'b0;
        rst     = 1'b0;
        cmp_en  = 1'b1;
        nops(2);

        // Back-to-back ALU dependency -> MEM forward.
        step(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
        nops(1);
        for (int k = 0; k < 3; k++) check("b2b forward_a", fa[k], 2'b10);

        // One independent instruction in between -> WB forward.
        step(1'b1, 5'd1, 5'd2, 5'd9,  1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd9, 5'd1, 5'd12, 1'b1, 1'b0, 1'b0);
        nops(1);
        for (int k = 0; k < 3; k++) begin
            check("gap1 forward_a", fa[k], 2'b01);
            check("gap1 forward_b", fb[k], 2'b00);
        end

        // x0 is never forwarded.
        step(1'b1, 5'd1, 5'd2, 5'd0,  1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        nops(1);
        for (int k = 0; k < 3; k++) begin
            check("x0 forward_a", fa[k], 2'b00);
            check("x0 forward_b", fb[k], 2'b00);
        end

        // Two writers of x7: MEM wins over WB.
        step(1'b1, 5'd1, 5'd2, 5'd7,  1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd3, 5'd4, 5'd7,  1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd1, 5'd7, 5'd14, 1'b1, 1'b0, 1'b0);
        nops(1);
        for (int k = 0; k < 3; k++) check("prio forward_b", fb[k], 2'b10);

        // Load-use, LOAD_LAT=1: one stall cycle, then WB forward.
        nops(4);
        step(1'b1, 5'd1, 5'd2, 5'd3,  1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0);
        check("lat1 stall_f c0", 2'(sf[0]), 2'b01);
        check("lat1 stall_d c0", 2'(sd[0]), 2'b01);
        check("lat1 flush_e c0", 2'(fe[0]), 2'b01);
        check("lat1 flush_d c0", 2'(fd[0]), 2'b00);
        step(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0);
        check("lat1 stall_f c1", 2'(sf[0]), 2'b00);
        check("lat1 flush_e c1", 2'(fe[0]), 2'b00);
        check("lat2 stall_f c1", 2'(sf[1]), 2'b01);
        nops(1);
        check("lat1 dep forward_a", fa[0], 2'b01);

        // Load-use, LOAD_LAT=3: three stall cycles, then no forward.
        nops(4);
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0);
            check($sformatf("lat3 stall_f c%0d", c), 2'(sf[2]), (c < 3) ? 2'b01 : 2'b00);
        end
        nops(1);
        check("lat3 dep forward_a", fa[2], 2'b00);

        // Reset one cycle into a LOAD_LAT=2 stall.
        nops(4);
        step(1'b1, 5'd1, 5'd2, 5'd3,  1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0);
        check("rstmid stall_f c0", 2'(sf[1]), 2'b01);
        step(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0);
        check("rstmid stall_f c1", 2'(sf[1]), 2'b01);
        #2 rst = 1'b1;
        #1;
        check("rstmid stall_f", 2'(sf[1]), 2'b00);
        check("rstmid stall_d", 2'(sd[1]), 2'b00);
        check("rstmid flush_e", 2'(fe[1]), 2'b00);
        check("rstmid forward_a", fa[1], 2'b00);
        check("rstmid forward_b", fb[1], 2'b00);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0);
        check("post-rst stall_f", 2'(sf[1]), 2'b00);
        check("post-rst flush_e", 2'(fe[1]), 2'b00);
        nops(1);
        check("post-rst stall_f n", 2'(sf[1]), 2'b00);

        // Branch in the same cycle as the load-use hazard.
        nops(4);
        step(1'b1, 5'd1, 5'd2, 5'd3,  1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("br+hz stall_f", 2'(sf[k]), 2'b00);
            check("br+hz flush_d", 2'(fd[k]), 2'b01);
            check("br+hz flush_e", 2'(fe[k]), 2'b01);
        end
        nops(1);
        for (int k = 0; k < 3; k++) check("br+hz next stall_f", 2'(sf[k]), 2'b00);

        // Branch in the second cycle of a LOAD_LAT=3 stall.
        nops(4);
        step(1'b1, 5'd1, 5'd2, 5'd3,  1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0);
        check("br-mid stall_f c0", 2'(sf[2]), 2'b01);
        step(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b1);
        check("br-mid stall_f c1", 2'(sf[2]), 2'b00);
        check("br-mid flush_d c1", 2'(fd[2]), 2'b01);
        check("br-mid flush_e c1", 2'(fe[2]), 2'b01);
        nops(1);
        check("br-mid stall_f c2", 2'(sf[2]), 2'b00);
        check("br-mid flush_e c2", 2'(fe[2]), 2'b00);

        nops(3);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
